// File: rtl/lzc_pkg.sv
// Shared definitions for the iterative leading-zero counter (lzc_seq).
// Holds the FSM state encoding, default geometry and the derived count and chunk widths.
package lzc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } lzc_state_e;

    localparam int LZC_WIDTH  = 32;
    localparam int LZC_STEP   = 4;
    localparam int LZC_CNT_W  = $clog2(LZC_WIDTH) + 1;
    localparam int LZC_CHUNKS = LZC_WIDTH / LZC_STEP;

    // The chunk index needs at least one bit, even when the operand is a single chunk.
    function automatic int lzc_chunk_w(input int chunks);
        return (chunks > 1) ? $clog2(chunks) : 1;
    endfunction

endpackage

// File: rtl/lzc_seq_nibble_lz.sv
// Combinational leading-zero count of one STEP-bit chunk.
// Returns STEP when the chunk is all zero.
module nibble_lz #(
    parameter int STEP = 4
)(
    input  logic [STEP-1:0]        bits,
    output logic [$clog2(STEP):0]  z
);

    localparam int ZW = $clog2(STEP) + 1;

    // Scanning upwards lets the highest set bit win, so z ends up as its distance from the MSB.
    always_comb begin
        z = ZW'(STEP);
        for (int i = 0; i < STEP; i++) begin
            if (bits[i]) begin
                z = ZW'(STEP - 1 - i);
            end
        end
    end

endmodule

// File: rtl/lzc_seq.sv
// Iterative leading-zero counter: scans a WIDTH-bit operand from the MSB, STEP bits per cycle.
// Build option LZC_EARLY_EXIT_EN: stop scanning at the first nonzero chunk (variable latency).
module lzc_seq
    import lzc_pkg::*;
#(
    parameter int WIDTH = LZC_WIDTH,
    parameter int STEP  = LZC_STEP
)(
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [$clog2(WIDTH):0]  out_count,
    output logic                    out_zero
);

    localparam int CNT_W   = $clog2(WIDTH) + 1;
    localparam int ZW      = $clog2(STEP) + 1;
    localparam int CHUNKS  = WIDTH / STEP;
    localparam int CHUNK_W = lzc_chunk_w(CHUNKS);

    localparam logic [CHUNK_W-1:0] LAST_CHUNK = CHUNK_W'(CHUNKS - 1);
    localparam logic [ZW-1:0]      Z_EMPTY    = ZW'(STEP);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(WIDTH);

    lzc_state_e           state;
    logic [WIDTH-1:0]     shreg;
    logic [CNT_W-1:0]     cnt;
    logic [CHUNK_W-1:0]   chunk;
    logic                 found;

    logic [ZW-1:0]        z;
    logic                 hit;
    logic [CNT_W-1:0]     cnt_add;
    logic [CNT_W-1:0]     cnt_result;
    logic                 last;

    nibble_lz #(
        .STEP (STEP)
    ) u_nibble_lz (
        .bits (shreg[WIDTH-1 -: STEP]),
        .z    (z)
    );

    // Once a nonzero chunk has been seen the count is frozen; later chunks are don't-care.
    assign hit        = (z != Z_EMPTY);
    assign cnt_add    = cnt + (hit ? CNT_W'(z) : CNT_W'(STEP));
    assign cnt_result = found ? cnt : cnt_add;
    assign last       = (chunk == LAST_CHUNK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_count <= '0;
            out_zero  <= 1'b0;
            shreg     <= '0;
            cnt       <= '0;
            chunk     <= '0;
            found     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        shreg    <= in_data;
                        cnt      <= '0;
                        chunk    <= '0;
                        found    <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SCAN;
                    end
                end

                SCAN: begin
                    if (!found) begin
                        cnt <= cnt_add;
                    end
                    if (hit) begin
                        found <= 1'b1;
                    end
                    shreg <= shreg << STEP;
                    chunk <= chunk + 1'b1;
`ifdef LZC_EARLY_EXIT_EN
                    if (hit || last) begin
`else
                    if (last) begin
`endif
                        out_count <= cnt_result;
                        out_zero  <= (cnt_result == CNT_FULL);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lzc_seq.sv
// Directed self-checking bench for lzc_seq; latency expectations follow LZC_EARLY_EXIT_EN.
module tb_lzc_seq;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  out_count;
    logic        out_zero;

    int passed;
    int total;

`ifdef LZC_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    lzc_seq dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Offer one operand, scramble in_data after acceptance, and measure cycles until out_valid.
    task automatic send_op(input logic [31:0] data, output int lat, output bit timed_out);
        @(negedge clock);
        in_data  = data;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = ~data;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        timed_out = !out_valid;
    endtask

    task automatic consume();
        @(negedge clock);
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL reset_in_ready got=%b exp=0", in_ready); else passed++;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_count !== 6'd0) $display("[TB] FAIL reset_out_count got=%0d exp=0", out_count); else passed++;
        total++; if (out_zero !== 1'b0) $display("[TB] FAIL reset_out_zero got=%b exp=0", out_zero); else passed++;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL idle_in_ready got=%b exp=1", in_ready); else passed++;
    endtask

    task automatic test_idle_out_ready();
        @(negedge clock);
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL idle_out_ready_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL idle_out_ready_in_ready got=%b exp=1", in_ready); else passed++;
        out_ready = 1'b0;
    endtask

    // Each row: operand, expected count, expected zero flag, latency with and without early exit.
    task automatic test_vectors();
        logic [31:0] vdata  [5] = '{32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 32'h00F0_0000, 32'h0001_2345};
        logic [5:0]  vcount [5] = '{6'd0, 6'd31, 6'd32, 6'd8, 6'd15};
        logic        vzero  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int          vlat_e [5] = '{2, 9, 9, 4, 5};
        int          lat;
        int          exp_lat;
        bit          to;
        for (int i = 0; i < 5; i++) begin
            send_op(vdata[i], lat, to);
            exp_lat = EARLY ? vlat_e[i] : 9;
            total++; if (to) $display("[TB] FAIL vec%0d_timeout out_valid never rose", i); else passed++;
            total++; if (lat != exp_lat) $display("[TB] FAIL vec%0d_latency got=%0d exp=%0d", i, lat, exp_lat); else passed++;
            total++; if (out_count !== vcount[i]) $display("[TB] FAIL vec%0d_count got=%0d exp=%0d", i, out_count, vcount[i]); else passed++;
            total++; if (out_zero !== vzero[i]) $display("[TB] FAIL vec%0d_zero got=%b exp=%b", i, out_zero, vzero[i]); else passed++;
            consume();
            total++; if (out_valid !== 1'b0) $display("[TB] FAIL vec%0d_drop got=%b exp=0", i, out_valid); else passed++;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        bit to;
        send_op(32'h00F0_0000, lat, to);
        total++; if (to) $display("[TB] FAIL bp_timeout out_valid never rose"); else passed++;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock);
            #1;
            total++; if (out_count !== 6'd8) $display("[TB] FAIL bp_count%0d got=%0d exp=8", c, out_count); else passed++;
            total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_in_ready%0d got=%b exp=0", c, in_ready); else passed++;
            total++; if (out_valid !== 1'b1) $display("[TB] FAIL bp_valid%0d got=%b exp=1", c, out_valid); else passed++;
        end
        @(negedge clock);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h8000_0000;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_handshake_valid got=%b exp=0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_handshake_in_ready got=%b exp=1", in_ready); else passed++;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_accept_in_ready got=%b exp=0", in_ready); else passed++;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clock);
            #1;
            lat++;
        end
        total++; if (out_count !== 6'd0 || out_valid !== 1'b1) $display("[TB] FAIL bp_next_count got=%0d valid=%b exp=0 valid=1", out_count, out_valid); else passed++;
        consume();
    endtask

    task automatic test_reset_mid_scan();
        int lat;
        bit to;
        @(negedge clock);
        in_data  = 32'h0000_0001;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) $display("[TB] FAIL midreset_valid got=%b exp=0", out_valid); else passed++;
        total++; if (out_count !== 6'd0) $display("[TB] FAIL midreset_count got=%0d exp=0", out_count); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        total++; if (in_ready !== 1'b1) $display("[TB] FAIL midreset_in_ready got=%b exp=1", in_ready); else passed++;
        send_op(32'h4000_0000, lat, to);
        total++; if (to) $display("[TB] FAIL midreset_timeout out_valid never rose"); else passed++;
        total++; if (lat != (EARLY ? 2 : 9)) $display("[TB] FAIL midreset_latency got=%0d exp=%0d", lat, EARLY ? 2 : 9); else passed++;
        total++; if (out_count !== 6'd1) $display("[TB] FAIL midreset_next_count got=%0d exp=1", out_count); else passed++;
        total++; if (out_zero !== 1'b0) $display("[TB] FAIL midreset_next_zero got=%b exp=0", out_zero); else passed++;
        consume();
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_idle_out_ready();
        test_vectors();
        test_backpressure();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
